// File: rtl/mips_cpu_bus_interface.sv
// Arbitrates MIPS instruction-fetch and load/store requests onto a single Avalon-MM master port.
// Data requests win over fetches; a stuck waitrequest aborts the transfer and sets a sticky error.
module mips_cpu_bus_interface #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_ready,
    output logic [31:0] instr_rdata,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_be,
    output logic        data_ready,
    output logic [31:0] data_rdata,
    output logic        bus_error,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = 4;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    address_q, address_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic [DW-1:0]    writedata_q, writedata_d;
    logic [BW-1:0]    byteenable_q, byteenable_d;
    logic             instr_ready_q, instr_ready_d;
    logic [DW-1:0]    instr_rdata_q, instr_rdata_d;
    logic             data_ready_q, data_ready_d;
    logic [DW-1:0]    data_rdata_q, data_rdata_d;
    logic             bus_error_q, bus_error_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             unused_addr_bits;

    // Byte-offset bits are dropped: the bus is word addressed.
    assign unused_addr_bits = ^{instr_addr[1:0], data_addr[1:0]};
    assign cnt_inc_c        = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            address_q     <= '0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            writedata_q   <= '0;
            byteenable_q  <= '0;
            instr_ready_q <= 1'b0;
            instr_rdata_q <= '0;
            data_ready_q  <= 1'b0;
            data_rdata_q  <= '0;
            bus_error_q   <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            read_q        <= read_d;
            write_q       <= write_d;
            writedata_q   <= writedata_d;
            byteenable_q  <= byteenable_d;
            instr_ready_q <= instr_ready_d;
            instr_rdata_q <= instr_rdata_d;
            data_ready_q  <= data_ready_d;
            data_rdata_q  <= data_rdata_d;
            bus_error_q   <= bus_error_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        read_d        = read_q;
        write_d       = write_q;
        writedata_d   = writedata_q;
        byteenable_d  = byteenable_q;
        instr_ready_d = 1'b0;
        instr_rdata_d = instr_rdata_q;
        data_ready_d  = 1'b0;
        data_rdata_d  = data_rdata_q;
        bus_error_d   = bus_error_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (data_req) begin
                    state_d      = DATA;
                    address_d    = {data_addr[AW-1:2], 2'b00};
                    read_d       = ~data_we;
                    write_d      = data_we;
                    writedata_d  = data_we ? data_wdata : '0;
                    byteenable_d = data_be;
                end else if (instr_req) begin
                    state_d      = INSTR;
                    address_d    = {instr_addr[AW-1:2], 2'b00};
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    writedata_d  = '0;
                    byteenable_d = {BW{1'b1}};
                end
            end
            INSTR, DATA: begin
                if (!waitrequest) begin
                    state_d = DONE;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (state_q == INSTR) begin
                        instr_ready_d = 1'b1;
                        instr_rdata_d = readdata;
                    end else begin
                        data_ready_d = 1'b1;
                        if (read_q) data_rdata_d = readdata;
                    end
                end else if (cnt_inc_c == CNT_W'(TIMEOUT)) begin
                    // Abort: complete towards the core with zero data and flag the error.
                    state_d     = DONE;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    bus_error_d = 1'b1;
                    cnt_d       = cnt_inc_c;
                    if (state_q == INSTR) begin
                        instr_ready_d = 1'b1;
                        instr_rdata_d = '0;
                    end else begin
                        data_ready_d = 1'b1;
                        if (read_q) data_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign address     = address_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = writedata_q;
    assign byteenable  = byteenable_q;
    assign instr_ready = instr_ready_q;
    assign instr_rdata = instr_rdata_q;
    assign data_ready  = data_ready_q;
    assign data_rdata  = data_rdata_q;
    assign bus_error   = bus_error_q;
endmodule

// File: tb/tb_mips_cpu_bus_interface.sv
// Table-driven bench for mips_cpu_bus_interface (TIMEOUT=4) plus an async-reset sequence.
module tb_mips_cpu_bus_interface;
    typedef struct packed {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dbe;
        logic        wreq;
        logic [31:0] rdata;
    } in_t;

    typedef struct packed {
        logic [31:0] address;
        logic        read;
        logic        write;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
        logic        instr_ready;
        logic [31:0] instr_rdata;
        logic        data_ready;
        logic [31:0] data_rdata;
        logic        bus_error;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req = 1'b0;
    logic [31:0] instr_addr = '0;
    logic        instr_ready;
    logic [31:0] instr_rdata;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_be = '0;
    logic        data_ready;
    logic [31:0] data_rdata;
    logic        bus_error;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest = 1'b0;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata = '0;

    int checks = 0;
    int errors = 0;
    out_t act;
    vec_t vecs[$];

    mips_cpu_bus_interface #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_ready(instr_ready), .instr_rdata(instr_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_be(data_be),
        .data_ready(data_ready), .data_rdata(data_rdata),
        .bus_error(bus_error),
        .address(address), .write(write), .read(read),
        .waitrequest(waitrequest), .writedata(writedata),
        .byteenable(byteenable), .readdata(readdata)
    );

    always #5 clk = ~clk;

    assign act = {address, read, write, writedata, byteenable,
                  instr_ready, instr_rdata, data_ready, data_rdata, bus_error};

    function automatic in_t vin(logic ireq, logic [31:0] iaddr, logic dreq, logic dwe,
                                logic [31:0] daddr, logic [31:0] dwdata, logic [3:0] dbe,
                                logic wreq, logic [31:0] rdata);
        return '{ireq, iaddr, dreq, dwe, daddr, dwdata, dbe, wreq, rdata};
    endfunction

    function automatic out_t vout(logic [31:0] a, logic rd, logic wr, logic [31:0] wd,
                                  logic [3:0] be, logic ir, logic [31:0] ird, logic dr,
                                  logic [31:0] drd, logic err);
        return '{a, rd, wr, wd, be, ir, ird, dr, drd, err};
    endfunction

    task automatic apply(input in_t v);
        instr_req   = v.ireq;
        instr_addr  = v.iaddr;
        data_req    = v.dreq;
        data_we     = v.dwe;
        data_addr   = v.daddr;
        data_wdata  = v.dwdata;
        data_be     = v.dbe;
        waitrequest = v.wreq;
        readdata    = v.rdata;
    endtask

    task automatic check(input string name, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got addr=%h rd=%b wr=%b wd=%h be=%h ir=%b ird=%h dr=%b drd=%h err=%b, want addr=%h rd=%b wr=%b wd=%h be=%h ir=%b ird=%h dr=%b drd=%h err=%b",
                     name, act.address, act.read, act.write, act.writedata, act.byteenable,
                     act.instr_ready, act.instr_rdata, act.data_ready, act.data_rdata, act.bus_error,
                     exp.address, exp.read, exp.write, exp.writedata, exp.byteenable,
                     exp.instr_ready, exp.instr_rdata, exp.data_ready, exp.data_rdata, exp.bus_error);
        end
    endtask

    initial begin
        in_t idle_in;
        in_t fetch_in, load_in, store_in, both_in, fetch2_in, tmo_in, good_in;
        idle_in   = vin(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        fetch_in  = vin(1, 32'hBFC00002, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h3C080001);
        load_in   = vin(0, 32'h0, 1, 0, 32'h00001006, 32'h0, 4'hC, 0, 32'h12345678);
        store_in  = vin(0, 32'h0, 1, 1, 32'h00001004, 32'hDEADBEEF, 4'h3, 1, 32'h0);
        both_in   = vin(1, 32'h00400000, 1, 0, 32'h00001000, 32'h0, 4'hF, 0, 32'hCAFEF00D);
        fetch2_in = vin(1, 32'h00400000, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0BADC0DE);
        tmo_in    = vin(0, 32'h0, 1, 0, 32'h00002000, 32'h0, 4'hF, 1, 32'h55555555);
        good_in   = vin(1, 32'h00000013, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h11112222);

        // fetch, zero wait
        vecs.push_back('{fetch_in, vout(32'hBFC00000, 1, 0, 0, 4'hF, 0, 0, 0, 0, 0)});
        vecs.push_back('{fetch_in, vout(32'hBFC00000, 0, 0, 0, 4'hF, 1, 32'h3C080001, 0, 0, 0)});
        vecs.push_back('{idle_in,  vout(32'hBFC00000, 0, 0, 0, 4'hF, 0, 32'h3C080001, 0, 0, 0)});
        // load, zero wait, unaligned address
        vecs.push_back('{load_in, vout(32'h00001004, 1, 0, 0, 4'hC, 0, 32'h3C080001, 0, 0, 0)});
        vecs.push_back('{load_in, vout(32'h00001004, 0, 0, 0, 4'hC, 0, 32'h3C080001, 1, 32'h12345678, 0)});
        vecs.push_back('{idle_in, vout(32'h00001004, 0, 0, 0, 4'hC, 0, 32'h3C080001, 0, 32'h12345678, 0)});
        // store with three wait cycles
        for (int k = 0; k < 4; k++)
            vecs.push_back('{store_in, vout(32'h00001004, 0, 1, 32'hDEADBEEF, 4'h3, 0, 32'h3C080001, 0, 32'h12345678, 0)});
        store_in.wreq = 0;
        vecs.push_back('{store_in, vout(32'h00001004, 0, 0, 32'hDEADBEEF, 4'h3, 0, 32'h3C080001, 1, 32'h12345678, 0)});
        vecs.push_back('{idle_in,  vout(32'h00001004, 0, 0, 32'hDEADBEEF, 4'h3, 0, 32'h3C080001, 0, 32'h12345678, 0)});
        // simultaneous requests: load first, fetch afterwards
        vecs.push_back('{both_in,   vout(32'h00001000, 1, 0, 0, 4'hF, 0, 32'h3C080001, 0, 32'h12345678, 0)});
        vecs.push_back('{both_in,   vout(32'h00001000, 0, 0, 0, 4'hF, 0, 32'h3C080001, 1, 32'hCAFEF00D, 0)});
        vecs.push_back('{fetch2_in, vout(32'h00001000, 0, 0, 0, 4'hF, 0, 32'h3C080001, 0, 32'hCAFEF00D, 0)});
        vecs.push_back('{fetch2_in, vout(32'h00400000, 1, 0, 0, 4'hF, 0, 32'h3C080001, 0, 32'hCAFEF00D, 0)});
        vecs.push_back('{fetch2_in, vout(32'h00400000, 0, 0, 0, 4'hF, 1, 32'h0BADC0DE, 0, 32'hCAFEF00D, 0)});
        vecs.push_back('{idle_in,   vout(32'h00400000, 0, 0, 0, 4'hF, 0, 32'h0BADC0DE, 0, 32'hCAFEF00D, 0)});
        // load timeout after four stuck wait cycles
        for (int k = 0; k < 4; k++)
            vecs.push_back('{tmo_in, vout(32'h00002000, 1, 0, 0, 4'hF, 0, 32'h0BADC0DE, 0, 32'hCAFEF00D, 0)});
        vecs.push_back('{tmo_in,  vout(32'h00002000, 0, 0, 0, 4'hF, 0, 32'h0BADC0DE, 1, 32'h0, 1)});
        vecs.push_back('{idle_in, vout(32'h00002000, 0, 0, 0, 4'hF, 0, 32'h0BADC0DE, 0, 32'h0, 1)});
        // good fetch with one wait cycle; error stays sticky
        vecs.push_back('{good_in, vout(32'h00000010, 1, 0, 0, 4'hF, 0, 32'h0BADC0DE, 0, 32'h0, 1)});
        vecs.push_back('{good_in, vout(32'h00000010, 1, 0, 0, 4'hF, 0, 32'h0BADC0DE, 0, 32'h0, 1)});
        good_in.wreq = 0;
        vecs.push_back('{good_in, vout(32'h00000010, 0, 0, 0, 4'hF, 1, 32'h11112222, 0, 32'h0, 1)});
        vecs.push_back('{idle_in, vout(32'h00000010, 0, 0, 0, 4'hF, 0, 32'h11112222, 0, 32'h0, 1)});

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", '0);
        reset = 1'b0;

        foreach (vecs[n]) begin
            apply(vecs[n].i);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", n), vecs[n].o);
        end

        // async reset in the middle of a wait state, request held across it
        apply(vin(1, 32'h00000040, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h77777777));
        @(posedge clk);
        #1;
        check("rst_seq_start", vout(32'h00000040, 1, 0, 0, 4'hF, 0, 32'h11112222, 0, 32'h0, 1));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_clear", '0);
        waitrequest = 1'b0;
        @(posedge clk);
        #1;
        check("rst_held_no_ready", '0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_reaccept", vout(32'h00000040, 1, 0, 0, 4'hF, 0, 32'h0, 0, 32'h0, 0));
        @(posedge clk);
        #1;
        check("rst_fetch_done", vout(32'h00000040, 0, 0, 0, 4'hF, 1, 32'h77777777, 0, 32'h0, 0));
        apply(idle_in);
        @(posedge clk);
        #1;
        check("rst_fetch_idle", vout(32'h00000040, 0, 0, 0, 4'hF, 0, 32'h77777777, 0, 32'h0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
